// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit packed-BCD adder/subtractor.
// It processes one decimal digit per clock, starting with the least-significant digit.
// Subtraction adds the nine's complement of B and sets the initial carry to ~borrow_in.
// This gives a ten's-complement difference, and the borrow is the inverted final carry.
//
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   start       - request, accepted only while busy=0 (IDLE or DONE)
//   mode        - 0 = a+b, 1 = a-b
//   a, b        - packed-BCD operands, digit 0 in bits [3:0]
//   carry_in    - carry-in (add) / borrow-in (subtract)
//   busy        - high while digits are being processed
//   done        - one-cycle pulse; result/flags valid from this cycle
//   result      - packed-BCD result, held until next accepted start
//   carry_out   - carry-out (add) / borrow-out (subtract)
//   invalid     - a captured operand digit was >9 (result forced to zero)
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry_out,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q;
    logic            mode_q;
    logic [IW-1:0]   idx;
    logic            c;
    logic            accept;
    logic            last;

    logic [3:0]      a_dig, b_dig, bd, dig;
    logic [4:0]      s;
    logic            c_nxt;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    assign accept = start && (state != S_RUN);
    assign last   = (idx == IW'(DIGITS - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last)   state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One decimal digit step: s = a_i + bd + c, with a +6 correction when s exceeds 9.
    always_comb begin
        a_dig = a_q[4*idx +: 4];
        b_dig = b_q[4*idx +: 4];
        bd    = mode_q ? (4'd9 - b_dig) : b_dig;
        s     = {1'b0, a_dig} + {1'b0, bd} + {4'b0, c};
        if (s > 5'd9) begin
            dig   = 4'(s + 5'd6);
            c_nxt = 1'b1;
        end else begin
            dig   = s[3:0];
            c_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            idx       <= '0;
            c         <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            invalid   <= 1'b0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b;
            mode_q    <= mode;
            idx       <= '0;
            c         <= mode ? ~carry_in : carry_in;
            result    <= '0;
            carry_out <= 1'b0;
            invalid   <= has_bad_digit(a) | has_bad_digit(b);
        end else if (state == S_RUN) begin
            result[4*idx +: 4] <= dig;
            c   <= c_nxt;
            idx <= idx + 1'b1;
            if (last) begin
                // Bad operands still take the full latency, but the result is forced to zero.
                carry_out <= invalid ? 1'b0 : (mode_q ? ~c_nxt : c_nxt);
                if (invalid) result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst, start, mode, carry_in;
    logic [W-1:0] a, b;
    logic         busy, done, carry_out, invalid;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;

    bcd_serial_addsub #(.DIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .invalid(invalid)
    );

    always #5 clk = ~clk;

    function automatic int pow10n();
        int p = 1;
        for (int i = 0; i < N; i++) p = p * 10;
        return p;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal reference: plain integer arithmetic modulo 10^N.
    function automatic void model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, output logic [W-1:0] r, output logic co);
        int p = pow10n();
        int v;
        if (!m) begin
            v  = bcd2int(x) + bcd2int(y) + int'(ci);
            co = (v >= p);
            r  = int2bcd(v % p);
        end else begin
            v  = bcd2int(x) - bcd2int(y) - int'(ci);
            co = (v < 0);
            r  = int2bcd(v < 0 ? v + p : v);
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Drives one request at a negedge, then counts edges from the accepting edge until done.
    // lat=-1 means done never appeared. busy_cnt counts samples with busy high.
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output int lat, output int busy_cnt);
        @(negedge clk);
        mode = m; a = x; b = y; carry_in = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; carry_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, carry_out, invalid} !== 4'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b co=%b inv=%b result=%h, required all 0",
                     busy, done, carry_out, invalid, result);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic         mv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] av[5]  = '{16'h9999, 16'h1234, 16'h5000, 16'h0003, 16'h0000};
        logic [W-1:0] bv[5]  = '{16'h0001, 16'h5678, 16'h1234, 16'h0005, 16'h0000};
        logic         cv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] rv[5]  = '{16'h0000, 16'h6913, 16'h3766, 16'h9998, 16'h9999};
        logic         cov[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(mv[i], av[i], bv[i], cv[i], lat, bc);
            checks++;
            if (lat != N || bc != N) begin
                failures++;
                $display("FAIL vec%0d latency: lat=%0d busy=%0d, required %0d/%0d", i, lat, bc, N, N);
            end
            checks++;
            if (result !== rv[i] || carry_out !== cov[i] || invalid !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d result: %h co=%b inv=%b, required %h co=%b inv=0",
                         i, result, carry_out, invalid, rv[i], cov[i]);
            end
            @(posedge clk) #1;
            checks++;
            if (done !== 1'b0 || result !== rv[i] || carry_out !== cov[i]) begin
                failures++;
                $display("FAIL vec%0d hold: done=%b result=%h co=%b", i, done, result, carry_out);
            end
        end
    endtask

    task automatic test_invalid();
        int lat, bc;
        run_op(1'b0, 16'h00A0, 16'h0001, 1'b0, lat, bc);
        checks++;
        if (lat != N || result !== '0 || carry_out !== 1'b0 || invalid !== 1'b1) begin
            failures++;
            $display("FAIL invalid: lat=%0d result=%h co=%b inv=%b, required %0d 0000 0 1",
                     lat, result, carry_out, invalid, N);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (invalid !== 1'b1 || result !== '0) begin
            failures++;
            $display("FAIL invalid_hold: inv=%b result=%h, required 1 0000", invalid, result);
        end
        run_op(1'b0, 16'h0011, 16'h0022, 1'b0, lat, bc);
        checks++;
        if (invalid !== 1'b0 || result !== 16'h0033 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL invalid_clear: inv=%b result=%h co=%b, required 0 0033 0",
                     invalid, result, carry_out);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        @(negedge clk);
        mode = 1'b0; a = 16'h0100; b = 16'h0200; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h7777; b = 16'h1111;           // start still high during RUN
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1; mode = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                checks++;
                if (result !== 16'h0300 || carry_out !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_result: result=%h co=%b, required 0300 0", result, carry_out);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignore_count: dones=%0d, required 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        int lat2 = -1;
        run_op(1'b0, 16'h0005, 16'h0005, 1'b0, lat, bc);
        // Now inside the DONE cycle; a new request here must be accepted.
        start = 1'b1; mode = 1'b1; a = 16'h0003; b = 16'h0005; carry_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat2 = k; break; end
        end
        checks++;
        if (lat2 != N || result !== 16'h9998 || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d result=%h co=%b, required %0d 9998 1",
                     lat2, result, carry_out, N);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        @(negedge clk);
        mode = 1'b0; a = 16'h4321; b = 16'h1111; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);                       // accepting edge
        #1 start = 1'b0;
        @(posedge clk);                       // first digit edge; now in 2nd RUN cycle
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, carry_out, invalid} !== 4'b0 || result !== '0) begin
            failures++;
            $display("FAIL rst_mid_run: busy=%b done=%b co=%b inv=%b result=%h, required all 0",
                     busy, done, carry_out, invalid, result);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_no_done: dones=%0d, required 0", dones);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, er;
        logic         m, ci, ec;
        int lat, bc;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = rand_bcd(); y = rand_bcd();
            m = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
            model(m, x, y, ci, er, ec);
            run_op(m, x, y, ci, lat, bc);
            checks++;
            if (lat != N || result !== er || carry_out !== ec || invalid !== 1'b0) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random%0d: m=%b a=%h b=%h ci=%b -> lat=%0d result=%h co=%b, required %0d %h %b",
                             i, m, x, y, ci, lat, result, carry_out, N, er, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised multi-digit packed-BCD adder/subtractor; processes one BCD digit per clock, least-significant digit first.
- Operands, mode and carry/borrow-in are captured on a start pulse. Result is returned with a one-cycle done pulse.
- Successor to the single-digit combinational BCD adder, for wide decimal counters and accumulators in the datapath.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = add (a+b), 1 = subtract (a-b)
- a  input  4*DIGITS  packed-BCD operand A; digit 0 in bits [3:0]
- b  input  4*DIGITS  packed-BCD operand B
- carry_in  input  1  add: carry-in; subtract: borrow-in
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  4*DIGITS  packed-BCD sum/difference, held until next accepted start
- carry_out  output  1  add: decimal carry-out; subtract: borrow-out
- invalid  output  1  some captured operand digit was >9

Behaviour:
- Single clock domain (clk). Synchronous active-high reset (rst).
- Reset forces the following:
  - State IDLE.
  - busy=0, done=0, result=0, carry_out=0, invalid=0.
  - Digit index=0; captured operands cleared.
- States:
  - IDLE: wait for start.
  - RUN: DIGITS cycles, one digit per cycle.
  - DONE: exactly 1 cycle, done=1, then IDLE.
- Accept rule:
  - start is accepted at a rising edge when state is IDLE or DONE (busy=0).
  - start while busy=1 is ignored and not queued.
- On accept:
  - Latch a, b, mode.
  - Set digit index=0.
  - Initial carry c = carry_in (add) or ~carry_in (subtract).
  - Clear the result register.
  - Compute invalid = any digit of a or b >9; latch it.
  - Enter RUN; busy=1 from the next cycle.
- Each RUN cycle on digit i:
  - Effective B digit: bd = b_i (add) or 9-b_i (subtract, nine's complement).
  - s = a_i + bd + c, 5-bit, range 0..19.
  - If s>9: digit = (s+6)[3:0], c=1. Else digit = s[3:0], c=0.
  - Write digit into result[4i+3:4i]; i increments.
- After digit DIGITS-1 is written at edge t(DIGITS):
  - State DONE, busy=0, done=1.
  - carry_out = c (add) or ~c (subtract).
  - Latency: done is high in the cycle following the DIGITS-th edge after the accepting edge.
- Subtract semantics:
  - Ten's-complement result. Borrow-out=1 when a < b + borrow_in.
  - Example: 0003-0005 gives result 9998, borrow 1.
- Invalid operands:
  - Computation still runs for full latency.
  - At done: result forced to all-zero, carry_out=0, invalid=1.
  - invalid is held until the next accepted start clears it.
- result, carry_out and invalid are held stable between done and the next accepted start.
- Intermediate result digits may change during RUN; consumers use done only.
- Back-to-back operation:
  - start during the DONE cycle is accepted.
  - done still pulses for exactly that one cycle; RUN begins next cycle.
- DIGITS=1: RUN lasts 1 cycle, done high 1 cycle after accept.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; no done pulse for the aborted operation.

Test Plan:
- DIGITS=4, add, a=0x9999, b=0x0001, carry_in=0 -> done exactly 4 cycles after accepting edge. result=0x0000, carry_out=1, invalid=0, busy high 4 cycles.
- Add, a=0x1234, b=0x5678, carry_in=1 -> result=0x6913, carry_out=0.
- Subtract, a=0x5000, b=0x1234, carry_in=0 -> result=0x3766, carry_out=0.
- Subtract, a=0x0003, b=0x0005, carry_in=0 -> result=0x9998, carry_out=1.
- Invalid digit: add, a=0x00A0, b=0x0001 -> done after 4 cycles with result=0x0000, carry_out=0, invalid=1. Next valid op clears invalid.
- Control sequence: start pulsed twice during RUN -> ignored, single done. start in the DONE cycle -> accepted, second done 4 cycles later. rst asserted in 2nd RUN cycle -> busy/done/result/carry_out/invalid all 0 next cycle and no done pulse.
- Random sweep: 1000 random valid operand/mode/carry triples vs decimal reference model -> exact match of result and carry_out.
